// File: rtl/bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// bcd_serial_addsub
//   Digit-serial packed-BCD adder/subtractor. One BCD digit is processed per
//   clock, least-significant digit first. Subtraction is done as
//   A + (9's complement of B) + 1, so carry_out means "no borrow" (A >= B).
//
// Parameters
//   DIGITS     number of BCD digits per operand (1..16)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new operation (accepted in IDLE or DONE)
//   sub        0 = add, 1 = subtract (A-B); sampled with start
//   a, b       packed BCD operands, digit 0 in bits [3:0]; sampled with start
//   busy       high while digits are being processed
//   done       one-cycle pulse: result/carry_out/err are valid
//   result     packed BCD result (forced to zero when err)
//   carry_out  add: decimal overflow; sub: 1 = no borrow
//   err        an operand nibble of the accepted request was > 9
// ---------------------------------------------------------------------------
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic             sub_q,       sub_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             carry_q,     carry_d;
  logic [W-1:0]     result_q,    result_d;
  logic             carry_out_q, carry_out_d;
  logic             err_q,       err_d;

  // Operand shift registers always present the current digit in [3:0].
  logic [3:0] b_adj;
  logic [4:0] sum;
  logic [3:0] digit;
  logic       digit_carry;
  logic       err_in;

  // NOTE: every variable written in an always_comb gets a default value
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    b_adj       = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    sum         = {1'b0, a_q[3:0]} + {1'b0, b_adj} + {4'b0, carry_q};
    digit       = sum[3:0];
    digit_carry = 1'b0;
    if (sum > 5'd9) begin
      // Adding 6 skips the six unused codes; bit 4 is dropped (mod 16).
      digit       = sum[3:0] + 4'd6;
      digit_carry = 1'b1;
    end
  end

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) err_in = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d         = a;
          b_d         = b;
          sub_d       = sub;
          idx_d       = '0;
          carry_d     = sub;   // +1 completes the 9's complement for subtract
          err_d       = err_in;
          result_d    = '0;
          carry_out_d = 1'b0;
          state_d     = S_RUN;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_RUN: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        carry_d  = digit_carry;
        // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
        result_d = (W'(digit) << (W - 4)) | (result_q >> 4);
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d     = S_DONE;
          carry_out_d = err_q ? 1'b0 : digit_carry;
          if (err_q) result_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_addsub
//   Directed testbench for bcd_serial_addsub with DIGITS=4. Inputs are driven
//   1 ns after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic        err;

  int total;
  int bad;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after the accepting edge (start already dropped). Counts
  // edges until done and busy samples along the way, then checks outputs.
  task automatic wait_done(input string name, input int exp_lat,
                           input logic [15:0] exp_res, input logic exp_c,
                           input logic exp_e);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    end
    total++;
    if (busy_cnt !== exp_lat) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_cnt, exp_lat);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy at done: got %b, expected 0", name, busy);
    end
    total++;
    if (result !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %h, expected %h", name, result, exp_res);
    end
    total++;
    if (carry_out !== exp_c) begin
      bad++;
      $display("FAIL %s carry_out: got %b, expected %b", name, carry_out, exp_c);
    end
    total++;
    if (err !== exp_e) begin
      bad++;
      $display("FAIL %s err: got %b, expected %b", name, err, exp_e);
    end
  endtask

  // One edge after done: the pulse must be gone and the outputs held.
  task automatic check_hold(input string name, input logic [15:0] exp_res,
                            input logic exp_c, input logic exp_e);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after done: got done=%b busy=%b, expected 0/0", name, done, busy);
    end
    total++;
    if (result !== exp_res || carry_out !== exp_c || err !== exp_e) begin
      bad++;
      $display("FAIL %s hold: got %h/%b/%b, expected %h/%b/%b",
               name, result, carry_out, err, exp_res, exp_c, exp_e);
    end
  endtask

  // Full operation; operands are scrambled while busy to show they are latched.
  task automatic do_op(input string name, input logic [15:0] ta,
                       input logic [15:0] tb_v, input logic ts,
                       input logic [15:0] exp_res, input logic exp_c,
                       input logic exp_e);
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_v; sub = ts;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~ts;
    wait_done(name, DIGITS, exp_res, exp_c, exp_e);
    check_hold(name, exp_res, exp_c, exp_e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    total++;
    if ({busy, done, result, carry_out, err} !== 20'h0) begin
      bad++;
      $display("FAIL reset outputs: got busy=%b done=%b result=%h c=%b err=%b, expected all 0",
               busy, done, result, carry_out, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    do_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    do_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_9999_9999", 16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0);
  endtask

  task automatic test_sub;
    do_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0);
    do_op("sub_0001_0002", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0);
    do_op("sub_0000_0000", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_err;
    do_op("err_00a0_0001", 16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_op("err_clears",    16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_run;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1234; b = 16'h5678; sub = 1'b0;
    @(posedge clk); #1;          // E0
    start = 1'b0;
    @(posedge clk); #1;          // E1
    start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b1;
    @(posedge clk); #1;          // E2
    start = 1'b0;
    wait_done("start_in_run", 2, 16'h6912, 1'b0, 1'b0);
    check_hold("start_in_run", 16'h6912, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1234; b = 16'h5678; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_first", DIGITS, 16'h6912, 1'b0, 1'b0);
    // Still in the DONE cycle: request the next operation now.
    start = 1'b1; a = 16'h5000; b = 16'h1234; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b accept: got busy=%b done=%b, expected 1/0", busy, done);
    end
    wait_done("b2b_second", DIGITS, 16'h3766, 1'b1, 1'b0);
    check_hold("b2b_second", 16'h3766, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    int done_seen;
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1234; b = 16'h5678; sub = 1'b0;
    @(posedge clk); #1;          // E0
    start = 1'b0;
    @(posedge clk); #1;          // E1
    @(posedge clk); #1;          // E2
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result, carry_out, err} !== 20'h0) begin
      bad++;
      $display("FAIL mid_run reset outputs: got busy=%b done=%b result=%h c=%b err=%b, expected all 0",
               busy, done, result, carry_out, err);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL mid_run no done: got %0d done cycles, expected 0", done_seen);
    end
    do_op("after_reset_5_5", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_sub();
    test_err();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
